dmem_arbiter: RTL and testbench

- Shares the single 64-word DataRAM between the CPU pipeline's MEM stage and a burst DMA/loader port.
- Sits between EX_MEM/MEM_WB and DataRAM. It drives the RAM address, data and write-enable, and returns read data to both requesters.
- The CPU has priority. A starvation counter guarantees DMA service. `cpu_stall` freezes the pipeline while DMA owns the RAM.

---
 rtl/dmem_arbiter.sv | 73 +++++++
 tb/tb_dmem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares DataRAM between the CPU MEM stage (priority) and a burst DMA port with starvation guard
module dmem_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [5:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [5:0]  dma_addr,
  input  logic [5:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_wready,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_done,
  output logic [5:0]  ram_a,
  output logic [31:0] ram_d,
  output logic        ram_we,
  input  logic [31:0] ram_spo
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] wait_cnt;
  logic [5:0] idx, addr_q, len_q;
  logic we_q, cpu_acc, at_max, go, last;
  assign cpu_acc = cpu_mem_read | cpu_mem_write;
  assign at_max = wait_cnt == 4'(MAX_WAIT);
  assign go = dma_req && (!cpu_acc || at_max);
  assign last = idx == len_q;
  assign cpu_rdata = ram_spo;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wait_cnt <= 4'd0;
      idx <= 6'd0;
      dma_rdata <= 32'd0;
      dma_rvalid <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      state <= state_nxt;
      dma_rvalid <= state == BURST && !we_q;
      dma_done <= state == BURST && last;
      if (state == BURST && !we_q) dma_rdata <= ram_spo;
      if (state == IDLE && go) begin
        addr_q <= dma_addr;
        len_q <= dma_len;
        we_q <= dma_we;
        idx <= 6'd0;
        wait_cnt <= 4'd0;
      end else if (state == IDLE) begin
        wait_cnt <= !dma_req ? 4'd0 : (cpu_acc && !at_max) ? wait_cnt + 4'd1 : wait_cnt;
      end else if (state == BURST) begin
        idx <= idx + 6'd1;
      end
    end
  end
  always_comb
    state_nxt = state == IDLE ? (go ? BURST : IDLE) : state == BURST ? (last ? DONE : BURST) : IDLE;
  // Outputs with side effects on the RAM or the pipeline are forced quiet while reset is held
  always_comb begin
    ram_a = state == BURST ? addr_q + idx : cpu_addr;
    ram_d = (state == BURST && we_q) ? dma_wdata : cpu_wdata;
    ram_we = reset && (state == IDLE ? cpu_mem_write && !(dma_req && at_max) : state == BURST && we_q);
    cpu_stall = reset && (state == IDLE ? cpu_acc && dma_req && at_max : cpu_acc);
    dma_wready = reset && state == BURST && we_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven cycle vectors plus reset corner sequences for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic cpu_mem_read, cpu_mem_write, dma_req, dma_we;
  logic [5:0] cpu_addr, dma_addr, dma_len;
  logic [31:0] cpu_wdata, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, ram_d, ram_spo;
  logic cpu_stall, dma_wready, dma_rvalid, dma_done, ram_we;
  logic [5:0] ram_a;
  logic [31:0] mem [64];
  int n_chk = 0;
  int n_fail = 0;
  int cur = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wready(dma_wready), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo)
  );

  assign ram_spo = mem[ram_a];
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;

  typedef struct {
    logic rd, wr;
    logic [5:0] ca;
    logic [31:0] cd;
    logic dq, dwe;
    logic [5:0] da, dl;
    logic [31:0] dd;
    logic stall, rwe;
    int ra;
    logic wrdy, rv;
    logic [31:0] rdata;
    logic done;
    longint crd;
  } vec_t;
  vec_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, cur, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_mem_read = v.rd; cpu_mem_write = v.wr; cpu_addr = v.ca; cpu_wdata = v.cd;
    dma_req = v.dq; dma_we = v.dwe; dma_addr = v.da; dma_len = v.dl; dma_wdata = v.dd;
  endtask

  task automatic idle_in();
    cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    // CPU store then load, no DMA
    q.push_back('{0,1,5,32'hDEADBEEF, 0,0,0,0,0, 0,1,5,0,0,0,0,-1});
    q.push_back('{1,0,5,0, 0,0,0,0,0, 0,0,5,0,0,0,0,32'hDEADBEEF});
    // DMA write burst 62..1 wrapping; request fields change mid-burst and must be ignored
    q.push_back('{0,0,0,0, 1,1,62,3,0, 0,0,0,0,0,0,0,-1});
    q.push_back('{0,0,0,0, 1,1,10,0,1, 0,1,62,1,0,0,0,-1});
    q.push_back('{0,0,0,0, 1,1,10,0,2, 0,1,63,1,0,0,0,-1});
    q.push_back('{0,0,0,0, 1,1,10,0,3, 0,1,0,1,0,0,0,-1});
    q.push_back('{0,0,0,0, 1,1,10,0,4, 0,1,1,1,0,0,0,-1});
    q.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,-1,0,0,0,1,-1});
    q.push_back('{1,0,62,0, 0,0,0,0,0, 0,0,62,0,0,0,0,1});
    q.push_back('{1,0,63,0, 0,0,0,0,0, 0,0,63,0,0,0,0,2});
    q.push_back('{1,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,3});
    q.push_back('{1,0,1,0, 0,0,0,0,0, 0,0,1,0,0,0,0,4});
    // DMA read burst of the same words
    q.push_back('{0,0,0,0, 1,0,62,3,0, 0,0,0,0,0,0,0,-1});
    q.push_back('{0,0,0,0, 1,0,0,0,0, 0,0,62,0,0,0,0,-1});
    q.push_back('{0,0,0,0, 1,0,0,0,0, 0,0,63,0,1,1,0,-1});
    q.push_back('{0,0,0,0, 1,0,0,0,0, 0,0,0,0,1,2,0,-1});
    q.push_back('{0,0,0,0, 1,0,0,0,0, 0,0,1,0,1,3,0,-1});
    q.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,-1,0,1,4,1,-1});
    q.push_back('{0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,4,0,-1});
    // Starvation: CPU loads every cycle while dma_req held
    for (int i = 0; i < 8; i++) q.push_back('{1,0,5,0, 1,0,5,0,0, 0,0,5,0,0,4,0,32'hDEADBEEF});
    q.push_back('{1,0,5,0, 1,0,5,0,0, 1,0,5,0,0,4,0,-1});
    q.push_back('{1,0,5,0, 0,0,0,0,0, 1,0,5,0,0,4,0,-1});
    q.push_back('{1,0,5,0, 0,0,0,0,0, 1,0,-1,0,1,32'hDEADBEEF,1,-1});
    q.push_back('{1,0,5,0, 0,0,0,0,0, 0,0,5,0,0,32'hDEADBEEF,0,32'hDEADBEEF});
    // CPU store held across a DMA write burst
    q.push_back('{0,0,0,0, 1,1,20,1,0, 0,0,0,0,0,32'hDEADBEEF,0,-1});
    q.push_back('{0,1,30,32'h1234, 0,0,0,0,32'hA, 1,1,20,1,0,32'hDEADBEEF,0,-1});
    q.push_back('{0,1,30,32'h1234, 0,0,0,0,32'hB, 1,1,21,1,0,32'hDEADBEEF,0,-1});
    q.push_back('{0,1,30,32'h1234, 0,0,0,0,0, 1,0,-1,0,0,32'hDEADBEEF,1,-1});
    q.push_back('{0,1,30,32'h1234, 0,0,0,0,0, 0,1,30,0,0,32'hDEADBEEF,0,-1});
    q.push_back('{1,0,30,0, 0,0,0,0,0, 0,0,30,0,0,32'hDEADBEEF,0,32'h1234});
    q.push_back('{1,0,20,0, 0,0,0,0,0, 0,0,20,0,0,32'hDEADBEEF,0,32'hA});
    q.push_back('{1,0,21,0, 0,0,0,0,0, 0,0,21,0,0,32'hDEADBEEF,0,32'hB});

    // Reset with a CPU store and DMA request pending: nothing may reach the RAM
    reset = 0;
    idle_in();
    cpu_mem_write = 1; cpu_addr = 9; cpu_wdata = 32'h55; dma_req = 1; dma_we = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst ram_we", 32'(ram_we), 0);
    chk("rst cpu_stall", 32'(cpu_stall), 0);
    chk("rst dma_wready", 32'(dma_wready), 0);
    chk("rst dma_rvalid", 32'(dma_rvalid), 0);
    chk("rst dma_done", 32'(dma_done), 0);
    chk("rst dma_rdata", dma_rdata, 0);
    @(negedge clk);
    reset = 1;
    idle_in();

    foreach (q[i]) begin
      @(negedge clk);
      cur = i;
      drive(q[i]);
      #1;
      chk("cpu_stall", 32'(cpu_stall), 32'(q[i].stall));
      chk("ram_we", 32'(ram_we), 32'(q[i].rwe));
      if (q[i].ra >= 0) chk("ram_a", 32'(ram_a), 32'(q[i].ra));
      chk("dma_wready", 32'(dma_wready), 32'(q[i].wrdy));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(q[i].rv));
      chk("dma_rdata", dma_rdata, q[i].rdata);
      chk("dma_done", 32'(dma_done), 32'(q[i].done));
      if (q[i].crd >= 0) chk("cpu_rdata", cpu_rdata, 32'(q[i].crd));
    end
    chk("mem30 once", mem[30], 32'h1234);

    // Reset in the second cycle of a 4-word write burst at 40
    cur = 1000;
    @(negedge clk);
    idle_in();
    dma_req = 1; dma_we = 1; dma_addr = 40; dma_len = 3;
    @(negedge clk);
    dma_req = 0; dma_wdata = 32'h11;
    #1;
    chk("abort w0 ram_we", 32'(ram_we), 1);
    chk("abort w0 ram_a", 32'(ram_a), 40);
    @(negedge clk);
    reset = 0; dma_wdata = 32'h22;
    #1;
    chk("abort rst ram_we", 32'(ram_we), 0);
    chk("abort rst wready", 32'(dma_wready), 0);
    @(negedge clk);
    reset = 1; dma_wdata = 32'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      cur = 1001 + i;
      chk("abort ram_we", 32'(ram_we), 0);
      chk("abort done", 32'(dma_done), 0);
      chk("abort rvalid", 32'(dma_rvalid), 0);
      chk("abort rdata", dma_rdata, 0);
      chk("abort wready", 32'(dma_wready), 0);
      @(negedge clk);
      cpu_mem_read = 1; cpu_addr = 6'(41 + i);
      #1;
      chk("abort idle stall", 32'(cpu_stall), 0);
      chk("abort idle ram_a", 32'(ram_a), 32'(41 + i));
      @(negedge clk);
      cpu_mem_read = 0;
    end
    chk("abort mem40", mem[40], 32'h11);
    chk("abort mem41", mem[41], 0);
    chk("abort mem42", mem[42], 0);
    chk("abort mem43", mem[43], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
